// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: read-after-write hazard unit beside the decode stage.
// A three-entry shift-register scoreboard (EXE, MEM, WB) records every
// in-flight register write. Decode stalls on RAW conflicts; the WB entry
// never stalls because the register file writes before it is read.
// Optional feature macro: HAZARD_FORWARDING_EN. When defined, only load-use
// stalls and registered operand-forwarding selects are produced for EXE.
// When undefined, the full-stall equation applies and the selects are tied 0.
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             Two_src,
  input  logic             id_WB_EN,
  input  logic             id_MEM_R_EN,
  input  logic [3:0]       id_Dest,
  input  logic             flush,
  output logic             hazard,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       is_load;
  } sb_entry_t;

  sb_entry_t        sb_exe_r;
  sb_entry_t        sb_mem_r;
  sb_entry_t        sb_wb_r;
  sb_entry_t        new_entry_s;
  logic             hazard_s;
  logic             bubble_s;
  logic             stall_inc_s;
  logic [CNT_W-1:0] stall_count_r;

  // The WB entry is only of interest to forwarding consumers downstream; the
  // is_load bits are only consulted in forwarding mode. Fold them into a sink.
  logic             sb_unused_s;
  assign sb_unused_s = ^{sb_wb_r, sb_mem_r.is_load, sb_exe_r.is_load, 2'(DEPTH)};

  function automatic logic sb_match(input sb_entry_t e, input logic [3:0] s);
    return e.valid && (e.dest == s);
  endfunction

  // Hazard equation: combinational from the scoreboard and the ID operands.
  always_comb begin
    hazard_s = 1'b0;
`ifdef HAZARD_FORWARDING_EN
    if (sb_exe_r.is_load) begin
      hazard_s = sb_match(sb_exe_r, src1) || (Two_src && sb_match(sb_exe_r, src2));
    end else begin
      hazard_s = 1'b0;
    end
`else
    hazard_s = sb_match(sb_exe_r, src1) || sb_match(sb_mem_r, src1) ||
               (Two_src && (sb_match(sb_exe_r, src2) || sb_match(sb_mem_r, src2)));
`endif
  end

  assign hazard = hazard_s;

  // Entry entering EXE: the ID instruction, or a bubble on stall/flush.
  always_comb begin
    bubble_s    = hazard_s || flush;
    new_entry_s = '0;
    if (bubble_s) begin
      new_entry_s = '0;
    end else begin
      new_entry_s = {id_WB_EN, id_Dest, id_MEM_R_EN};
    end
  end

  // Flush wins over hazard: an annulled instruction's stall is not counted.
  always_comb begin
    stall_inc_s = 1'b0;
    if (hazard_s && !flush && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_inc_s = 1'b1;
    end else begin
      stall_inc_s = 1'b0;
    end
  end

  // Scoreboard shift register; advances unconditionally every edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sb_exe_r <= '0;
      sb_mem_r <= '0;
      sb_wb_r  <= '0;
    end else begin
      sb_wb_r  <= sb_mem_r;
      sb_mem_r <= sb_exe_r;
      sb_exe_r <= new_entry_s;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (stall_inc_s) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;

`ifdef HAZARD_FORWARDING_EN
  logic [1:0] sel_src1_r;
  logic [1:0] sel_src2_r;
  logic [1:0] sel_src1_s;
  logic [1:0] sel_src2_s;

  // Youngest producer wins: EXE (MEM result next cycle) before MEM (WB result).
  function automatic logic [1:0] fwd_sel(input sb_entry_t exe_e,
                                         input sb_entry_t mem_e,
                                         input logic [3:0] s);
    logic [1:0] sel;
    if (sb_match(exe_e, s)) begin
      sel = 2'd1;
    end else if (sb_match(mem_e, s)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Next forward selects for the instruction leaving ID; zero for a bubble.
  always_comb begin
    sel_src1_s = 2'd0;
    sel_src2_s = 2'd0;
    if (bubble_s) begin
      sel_src1_s = 2'd0;
      sel_src2_s = 2'd0;
    end else begin
      sel_src1_s = fwd_sel(sb_exe_r, sb_mem_r, src1);
      if (Two_src) begin
        sel_src2_s = fwd_sel(sb_exe_r, sb_mem_r, src2);
      end else begin
        sel_src2_s = 2'd0;
      end
    end
  end

  // Selects travel with the instruction into EXE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sel_src1_r <= 2'd0;
      sel_src2_r <= 2'd0;
    end else begin
      sel_src1_r <= sel_src1_s;
      sel_src2_r <= sel_src2_s;
    end
  end

  assign sel_src1 = sel_src1_r;
  assign sel_src2 = sel_src2_r;
`else
  assign sel_src1 = 2'd0;
  assign sel_src2 = 2'd0;
`endif

endmodule
